// File: rtl/digi_ota_bank.sv
// Bank of NCH digitised comparator channels: each vip/vin pair is synchronised,
// filtered for FILT agreeing samples, then committed to out with oe/chg status.
module digi_ota_bank #(
  parameter int NCH  = 4,
  parameter int FILT = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           mode,
  input  logic [NCH-1:0] vip,
  input  logic [NCH-1:0] vin,
  output logic [NCH-1:0] out,
  output logic [NCH-1:0] oe,
  output logic [NCH-1:0] chg
);

  localparam int             CW     = $clog2(FILT + 1);
  localparam logic [CW-1:0]  FILT_C = CW'(FILT);
  localparam logic [CW-1:0]  ONE_C  = CW'(1);

  logic [NCH-1:0] r_vip_s1, r_vin_s1, r_vs, r_ns;
  logic [NCH-1:0] r_pol, r_out, r_valid, r_oe, r_chg;
  logic [CW-1:0]  r_cnt [NCH];

  logic [NCH-1:0] w_pol_nxt, w_out_nxt, w_valid_nxt, w_oe_nxt, w_chg_nxt;
  logic [CW-1:0]  w_cnt_nxt [NCH];
  logic [NCH-1:0] w_commit;

  // Per-channel filter decision; channels share nothing but en and mode.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no path leaves it unassigned (no latch).
    w_pol_nxt   = r_pol;
    w_out_nxt   = r_out;
    w_valid_nxt = r_valid;
    w_oe_nxt    = '0;
    w_chg_nxt   = '0;
    w_commit    = '0;
    for (int i = 0; i < NCH; i++) begin
      w_cnt_nxt[i] = '0;
      if (en) begin
        if (r_vs[i] ^ r_ns[i]) begin
          if (r_vs[i] != r_pol[i]) begin
            w_pol_nxt[i] = r_vs[i];
            w_cnt_nxt[i] = ONE_C;
            w_commit[i]  = (FILT == 1);
          end else if (r_cnt[i] != FILT_C) begin
            w_cnt_nxt[i] = r_cnt[i] + ONE_C;
            w_commit[i]  = (r_cnt[i] + ONE_C) == FILT_C;
          end else begin
            w_cnt_nxt[i] = r_cnt[i];
          end
          if (w_commit[i]) begin
            w_out_nxt[i]   = r_vs[i];
            w_valid_nxt[i] = 1'b1;
          end
        end
        w_oe_nxt[i] = (w_cnt_nxt[i] == FILT_C) | (mode & w_valid_nxt[i]);
      end
      w_chg_nxt[i] = w_out_nxt[i] ^ r_out[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vip_s1 <= '0;
      r_vin_s1 <= '0;
      r_vs     <= '0;
      r_ns     <= '0;
      r_pol    <= '0;
      r_out    <= '0;
      r_valid  <= '0;
      r_oe     <= '0;
      r_chg    <= '0;
      // NOTE: the small counter array is reset like any register so a reset discards partial counts.
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
    end else begin
      r_vip_s1 <= vip;
      r_vin_s1 <= vin;
      r_vs     <= r_vip_s1;
      r_ns     <= r_vin_s1;
      r_pol    <= w_pol_nxt;
      r_out    <= w_out_nxt;
      r_valid  <= w_valid_nxt;
      r_oe     <= w_oe_nxt;
      r_chg    <= w_chg_nxt;
      for (int i = 0; i < NCH; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  assign out = r_out;
  assign oe  = r_oe;
  assign chg = r_chg;

endmodule

// File: tb/tb_digi_ota_bank.sv
// Self-checking bench for digi_ota_bank: directed scenarios with literal checks,
// then randomized stimulus compared every cycle against a run-length model.
module tb_digi_ota_bank;

  localparam int NCH  = 4;
  localparam int FILT = 3;

  logic           clk, rst, en, mode;
  logic [NCH-1:0] vip, vin, out, oe, chg;

  int checks   = 0;
  int failures = 0;

  // Model: inputs seen two edges late, plus the length of the current run of
  // enabled, disagreeing samples that all point the same way.
  logic [NCH-1:0] hist_p[$], hist_n[$];
  int             m_run  [NCH];
  bit             m_cand [NCH];
  logic [NCH-1:0] m_out, m_valid, m_oe, m_chg;
  logic [NCH-1:0] chg_seen;

  digi_ota_bank #(.NCH(NCH), .FILT(FILT)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .mode(mode),
    .vip (vip),
    .vin (vin),
    .out (out),
    .oe  (oe),
    .chg (chg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist_p = {'0, '0};
    hist_n = {'0, '0};
    for (int c = 0; c < NCH; c++) begin
      m_run[c]  = 0;
      m_cand[c] = 1'b0;
    end
    m_out = '0; m_valid = '0; m_oe = '0; m_chg = '0;
  endtask

  task automatic model_edge();
    logic [NCH-1:0] sp, sn;
    bit commit;
    sp = hist_p.pop_front();
    sn = hist_n.pop_front();
    hist_p.push_back(vip);
    hist_n.push_back(vin);
    for (int c = 0; c < NCH; c++) begin
      m_chg[c] = 1'b0;
      if (!en) begin
        m_run[c] = 0;
        m_oe[c]  = 1'b0;
      end else if (sp[c] == sn[c]) begin
        m_run[c] = 0;
        m_oe[c]  = mode & m_valid[c];
      end else begin
        commit = 1'b0;
        if (m_run[c] > 0 && m_cand[c] == sp[c]) begin
          if (m_run[c] < FILT) begin
            m_run[c]++;
            commit = (m_run[c] == FILT);
          end
        end else begin
          m_run[c] = 1;
          commit   = (FILT == 1);
        end
        m_cand[c] = sp[c];
        if (commit) begin
          m_chg[c]   = (m_out[c] != sp[c]);
          m_out[c]   = sp[c];
          m_valid[c] = 1'b1;
        end
        m_oe[c] = (m_run[c] == FILT) || (mode && m_valid[c]);
      end
    end
  endtask

  task automatic compare();
    check("out", 32'(out), 32'(m_out));
    check("oe",  32'(oe),  32'(m_oe));
    check("chg", 32'(chg), 32'(m_chg));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    compare();
    chg_seen |= chg;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Asserts reset mid-cycle, holds it across one edge, releases it mid-cycle.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare();
    tick();
    #3 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b0;
    vip = 4'b0001; vin = 4'b0000;
    chg_seen = '0;
    model_reset();
    #1;
    check("reset_out", 32'(out), 32'h0);
    check("reset_oe",  32'(oe),  32'h0);
    check("reset_chg", 32'(chg), 32'h0);
    ticks(2);
    #3 rst = 1'b0;

    // Channel 0 disagrees through reset; commit only at edge 5 after release.
    ticks(4);
    check("ch0_pre_commit_out", 32'(out), 32'h0);
    tick();
    check("ch0_commit_out", 32'(out), 32'b0001);
    check("ch0_commit_oe",  32'(oe),  32'b0001);
    check("ch0_commit_chg", 32'(chg), 32'b0001);
    tick();
    check("ch0_chg_one_cycle", 32'(chg), 32'h0);

    // Tie on channel 0 releases oe in mode 0; keeper mode drives it again.
    vin[0] = 1'b1;
    ticks(2);
    check("ch0_tie_oe_before", 32'(oe[0]), 32'h1);
    tick();
    check("ch0_tie_oe", 32'(oe[0]), 32'h0);
    check("ch0_tie_out", 32'(out[0]), 32'h1);
    mode = 1'b1;
    tick();
    check("ch0_keeper_oe", 32'(oe[0]), 32'h1);
    check("ch0_keeper_out", 32'(out[0]), 32'h1);
    mode = 1'b0;
    tick();

    // Two-sample glitch on channel 1 is rejected.
    chg_seen = '0;
    vip[1] = 1'b1;
    ticks(2);
    vip[1] = 1'b0;
    ticks(6);
    check("ch1_glitch_out", 32'(out[1]), 32'h0);
    check("ch1_glitch_chg", 32'(chg_seen[1]), 32'h0);

    // Channel 2 flips polarity every two cycles, then settles to 0.
    chg_seen = '0;
    for (int k = 0; k < 20; k++) begin
      {vip[2], vin[2]} = ((k / 2) % 2 == 0) ? 2'b01 : 2'b10;
      tick();
    end
    check("ch2_alt_out", 32'(out[2]), 32'h0);
    check("ch2_alt_chg", 32'(chg_seen[2]), 32'h0);
    {vip[2], vin[2]} = 2'b01;
    ticks(4);
    check("ch2_hold_oe_pre", 32'(oe[2]), 32'h0);
    tick();
    check("ch2_hold_oe", 32'(oe[2]), 32'h1);
    check("ch2_hold_out", 32'(out[2]), 32'h0);
    check("ch2_hold_chg", 32'(chg_seen[2]), 32'h0);

    // Channel 3: en drops mid-count, then three enabled edges commit.
    {vip[3], vin[3]} = 2'b10;
    ticks(4);
    en = 1'b0;
    ticks(2);
    check("ch3_frozen_out", 32'(out[3]), 32'h0);
    check("ch3_frozen_oe", 32'(oe), 32'h0);
    en = 1'b1;
    ticks(2);
    check("ch3_reen_pre_out", 32'(out[3]), 32'h0);
    tick();
    check("ch3_reen_out", 32'(out[3]), 32'h1);
    check("ch3_reen_chg", 32'(chg[3]), 32'h1);

    // Reset in the middle of a count on channel 1 clears everything at once.
    vip[1] = 1'b1;
    ticks(3);
    #2 rst = 1'b1;
    #1;
    check("midrst_out", 32'(out), 32'h0);
    check("midrst_oe",  32'(oe),  32'h0);
    check("midrst_chg", 32'(chg), 32'h0);
    model_reset();
    tick();
    #3 rst = 1'b0;

    // All channels flip together; every commit lands on the same edge.
    vip = 4'b1111; vin = 4'b0000;
    ticks(4);
    check("all_pre_chg", 32'(chg), 32'h0);
    tick();
    check("all_chg", 32'(chg), 32'b1111);
    check("all_out", 32'(out), 32'b1111);
    tick();
    check("all_chg_end", 32'(chg), 32'h0);

    // Randomized traffic; the per-cycle compare in tick() does the checking.
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset();
      end else begin
        for (int c = 0; c < NCH; c++)
          if ($urandom_range(0, 5) == 0) {vip[c], vin[c]} = 2'($urandom);
        en = ($urandom_range(0, 19) != 0);
        if ($urandom_range(0, 15) == 0) mode = ~mode;
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
